// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift / load / rotate in either direction,
// plus a counted burst engine (IDLE -> RUN -> DONE) that repeats one shift or rotate step.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  // Burst handshake: start is accepted only while idle (busy=0, done=0).
  // busy stays high for exactly count cycles, then done pulses for one cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rot_q, rot_d;
  logic             dir_q, dir_d;

  // One shift/rotate step; rotate recirculates the outgoing bit instead of ser_in.
  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] cur,
                                               input logic rot,
                                               input logic left,
                                               input logic sin);
    logic fill;
    fill = sin;
    if (left) begin
      if (rot) fill = cur[WIDTH-1];
      step_fn = {cur[WIDTH-2:0], fill};
    end else begin
      if (rot) fill = cur[0];
      step_fn = {fill, cur[WIDTH-1:1]};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    dir_d   = dir_q;
    case (state_q)
      S_RUN: begin
        q_d   = step_fn(q_q, rot_q, dir_q, ser_in);
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DONE;
      end
      default: begin
        if (state_q == S_IDLE && start) begin
          rot_d   = (mode == 2'b11);
          dir_d   = dir;
          cnt_d   = count;
          state_d = (count == '0) ? S_DONE : S_RUN;
        end else begin
          // DONE (or any stray encoding) lasts one cycle; direct ops still apply.
          if (state_q != S_IDLE) state_d = S_IDLE;
          if (en) begin
            case (mode)
              2'b01:   q_d = step_fn(q_q, 1'b0, dir, ser_in);
              2'b10:   q_d = pdata;
              2'b11:   q_d = step_fn(q_q, 1'b1, dir, ser_in);
              default: q_d = q_q;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      rot_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      dir_q   <= dir_d;
    end
  end

  assign q         = q_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[WIDTH-1];
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed scenarios plus random traffic, all checked
// against an arithmetic reference model of the register and burst timing.
module tb_shift_reg_univ;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       dir;
  logic       ser_in;
  logic [7:0] pdata;
  logic       start;
  logic [3:0] count;
  logic [7:0] q;
  logic       ser_out_r;
  logic       ser_out_l;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_q;
  int         m_left;
  bit         m_done;
  bit         m_rot;
  bit         m_dir;

  shift_reg_univ #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .dir       (dir),
    .ser_in    (ser_in),
    .pdata     (pdata),
    .start     (start),
    .count     (count),
    .q         (q),
    .ser_out_r (ser_out_r),
    .ser_out_l (ser_out_l),
    .busy      (busy),
    .done      (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // op: 0 hold, 1 shift, 2 load, 3 rotate; d: 1 = left
  function automatic logic [7:0] m_apply(input int op, input bit d, input bit s,
                                         input logic [7:0] pd, input logic [7:0] cur);
    int v;
    int fill;
    v = int'(cur);
    case (op)
      1, 3: begin
        if (op == 3) fill = d ? (v / 128) : (v % 2);
        else         fill = int'(s);
        if (d) v = ((v * 2) % 256) + fill;
        else   v = (v / 2) + fill * 128;
      end
      2:       v = int'(pd);
      default: v = v;
    endcase
    return v[7:0];
  endfunction

  task automatic model_edge();
    if (m_left > 0) begin
      m_q = m_apply(m_rot ? 3 : 1, m_dir, ser_in, 8'h00, m_q);
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (!m_done && start) begin
      m_rot = (mode == 2'b11);
      m_dir = dir;
      if (count == 0) m_done = 1;
      else            m_left = int'(count);
    end else begin
      m_done = 0;
      if (en) m_q = m_apply(int'(mode), dir, ser_in, pdata, m_q);
    end
  endtask

  task automatic model_reset();
    m_q = 8'h00; m_left = 0; m_done = 0; m_rot = 0; m_dir = 0;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_q"},    32'(q),         32'(m_q));
    check_eq({tag, "_busy"}, 32'(busy),      32'(m_left > 0));
    check_eq({tag, "_done"}, 32'(done),      32'(m_done));
    check_eq({tag, "_sor"},  32'(ser_out_r), 32'(int'(m_q) % 2));
    check_eq({tag, "_sol"},  32'(ser_out_l), 32'(int'(m_q) / 128));
  endtask

  // Driver: apply inputs, advance one edge, sample 1 time unit later
  task automatic step(input string tag, input bit i_en, input logic [1:0] i_mode,
                      input bit i_dir, input bit i_ser, input logic [7:0] i_pd,
                      input bit i_start, input logic [3:0] i_cnt);
    en = i_en; mode = i_mode; dir = i_dir; ser_in = i_ser;
    pdata = i_pd; start = i_start; count = i_cnt;
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_step(input string tag);
    step(tag, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
  endtask

  initial begin
    logic [7:0] exp35[3];
    int n_busy;
    int n_done;
    exp35[0] = 8'h03; exp35[1] = 8'h06; exp35[2] = 8'h0C;

    rst_n = 1'b0; en = 0; mode = 0; dir = 0; ser_in = 0; pdata = 0; start = 0; count = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_q", 32'(q), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load then shift right with ser_in=1
    step("load_a5", 1, 2'b10, 0, 0, 8'hA5, 0, 4'd0);
    check_eq("load_a5_const", 32'(q), 32'hA5);
    step("shr", 1, 2'b01, 0, 1, 8'h00, 0, 4'd0);
    check_eq("shr_const", 32'(q), 32'hD2);
    check_eq("shr_sor", 32'(ser_out_r), 32'h0);
    check_eq("shr_sol", 32'(ser_out_l), 32'h1);

    // Shift left then rotate left
    step("load_a5b", 1, 2'b10, 0, 0, 8'hA5, 0, 4'd0);
    step("shl", 1, 2'b01, 1, 0, 8'h00, 0, 4'd0);
    check_eq("shl_const", 32'(q), 32'h4A);
    step("rol", 1, 2'b11, 1, 1, 8'h00, 0, 4'd0);
    check_eq("rol_const", 32'(q), 32'h94);

    // en=0 holds regardless of mode
    step("en_off", 0, 2'b10, 0, 1, 8'h3C, 0, 4'd0);
    check_eq("en_off_const", 32'(q), 32'h94);

    // Burst rotate-left, count=3, from 0x81
    step("load_81", 1, 2'b10, 0, 0, 8'h81, 0, 4'd0);
    step("b3_start", 1, 2'b11, 1, 0, 8'hFF, 1, 4'd3);
    check_eq("b3_start_q", 32'(q), 32'h81);
    check_eq("b3_start_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      idle_step("b3_run");
      check_eq("b3_q", 32'(q), 32'(exp35[i]));
      check_eq("b3_busy", 32'(busy), (i < 2) ? 32'h1 : 32'h0);
      check_eq("b3_done", 32'(done), (i == 2) ? 32'h1 : 32'h0);
    end
    idle_step("b3_after");
    check_eq("b3_done_clr", 32'(done), 32'h0);

    // Zero-length burst
    step("b0_start", 0, 2'b01, 0, 1, 8'h00, 1, 4'd0);
    check_eq("b0_done", 32'(done), 32'h1);
    check_eq("b0_busy", 32'(busy), 32'h0);
    check_eq("b0_q", 32'(q), 32'h0C);
    idle_step("b0_after");
    check_eq("b0_done_clr", 32'(done), 32'h0);

    // Burst of 5 with noise on ignored inputs
    n_busy = 0; n_done = 0;
    step("b5_start", 1, 2'b01, 0, 1'($urandom_range(0, 1)), 8'h00, 1, 4'd5);
    n_busy += int'(busy); n_done += int'(done);
    for (int i = 0; i < 6; i++) begin
      step("b5_run", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           (i < 4) ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom));
      n_busy += int'(busy); n_done += int'(done);
    end
    check_eq("b5_busy_cycles", 32'(n_busy), 32'd5);
    check_eq("b5_done_pulses", 32'(n_done), 32'd1);

    // Asynchronous reset in the middle of a long burst
    step("load_ff", 1, 2'b10, 0, 0, 8'hFF, 0, 4'd0);
    step("b9_start", 0, 2'b11, 0, 0, 8'h00, 1, 4'd9);
    repeat (3) idle_step("b9_run");
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("arst_q", 32'(q), 32'h0);
    check_eq("arst_busy", 32'(busy), 32'h0);
    check_eq("arst_done", 32'(done), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle_step("post_rst");
    check_eq("post_rst_done", 32'(done), 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           (!m_done && $urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range >= 2).
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the burst count input.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit, which enables a direct (single-cycle) operation.
REQ-006 The block SHALL have port mode, input, 2 bits, operation select: 00 hold, 01 shift, 10 parallel load, 11 rotate.
REQ-007 The block SHALL have port dir, input, 1 bit, direction: 0 right (toward q[0]), 1 left (toward q[WIDTH-1]).
REQ-008 The block SHALL have port ser_in, input, 1 bit, serial data input.
REQ-009 The block SHALL have port pdata, input, WIDTH bits, parallel load data.
REQ-010 The block SHALL have port start, input, 1 bit, burst request.
REQ-011 The block SHALL have port count, input, CNT_W bits, number of burst steps.
REQ-012 The block SHALL have port q, output, WIDTH bits, register contents, with q[WIDTH-1] as MSB.
REQ-013 The block SHALL have port ser_out_r, output, 1 bit, combinational copy of q[0].
REQ-014 The block SHALL have port ser_out_l, output, 1 bit, combinational copy of q[WIDTH-1].
REQ-015 The block SHALL have port busy, output, 1 bit, high while a burst is executing.
REQ-016 The block SHALL have port done, output, 1 bit, one-cycle pulse at burst completion.

Function
REQ-017 A right shift SHALL perform q <= {ser_in, q[WIDTH-1:1]}.
REQ-018 A left shift SHALL perform q <= {q[WIDTH-2:0], ser_in}.
REQ-019 A right rotate SHALL perform q <= {q[0], q[WIDTH-1:1]}, and a left rotate SHALL perform q <= {q[WIDTH-2:0], q[WIDTH-1]}.
REQ-020 A parallel load SHALL perform q <= pdata; hold SHALL leave q unchanged.
REQ-021 The controller SHALL use three states: IDLE, RUN, DONE.
REQ-022 In IDLE or DONE, when start=0 and en=1, the block SHALL perform the operation selected by mode/dir at that edge; en=0 SHALL hold q.
REQ-023 In IDLE with start=1, the block SHALL capture the burst operation (rotate if mode=11, otherwise shift), dir and count, SHALL NOT modify q at that edge, and SHALL ignore en.
REQ-024 On that IDLE start edge, the block SHALL go to RUN if count!=0, or to DONE if count=0.
REQ-025 In RUN, the block SHALL perform exactly one captured step per cycle for count cycles, with ser_in sampled live each cycle; it SHALL enter DONE on the edge of the last step.
REQ-026 In RUN, en, mode, dir, pdata, start and count SHALL be ignored.
REQ-027 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-028 start in RUN or DONE SHALL be ignored; a new burst is accepted only in IDLE.
REQ-029 Burst latency SHALL be: start sampled at edge k; busy high from k to k+count; done high from k+count to k+count+1.
REQ-030 A count greater than WIDTH SHALL be legal; step count SHALL NOT be truncated to WIDTH.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, force q=0, state IDLE, busy=0, done=0 and the internal step counter to 0, including in the middle of a burst.
REQ-032 After rst_n rises, the first operation SHALL occur no earlier than the next rising clk edge.

Verification (WIDTH=8, CNT_W=4)
REQ-033 Load 0xA5 (en=1, mode=10), then en=1, mode=01, dir=0, ser_in=1 -> q=0xD2, ser_out_r=0, ser_out_l=1.
REQ-034 From 0xA5: en=1, mode=01, dir=1, ser_in=0 -> q=0x4A; then mode=11, dir=1 -> q=0x94.
REQ-035 From 0x81: start=1, mode=11, dir=1, count=3 -> busy high 3 cycles, q steps 0x03, 0x06, 0x0C, then done pulses once for 1 cycle.
REQ-036 start=1, count=0 -> done pulses the cycle after, busy never asserts, q unchanged.
REQ-037 During a burst of count=5, toggling start/en/mode/pdata -> no effect; exactly 5 steps occur and a single done pulse follows.
REQ-038 Assert rst_n=0 mid-burst, between edges -> q=0x00 and busy=0 immediately; after release, the block idles with done=0.
